// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX shifter and baud generator among N_REQ packet sources.
// Optional per-packet header (0x55, 0xA0|src) enabled by defining UART_SCHED_HDR_EN.
module uart_tx_sched #(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned TIMEOUT_CYC = 50_000
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_last,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  input  logic                 tx_done,
  output logic                 bps_clk_en,
  output logic                 pkt_abort
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
`ifdef UART_SCHED_HDR_EN
    HDR0,
    HDR1,
`endif
    SEND,
    WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               bps_q, bps_d;
  logic               abort_q, abort_d;
  logic               lflag_q, lflag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic               win_found;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % N_REQ);
      if (!win_found && req_valid[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Byte lane of the current owner.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_q[i]) begin
        sel_valid = sel_valid | req_valid[i];
        sel_last  = sel_last | req_last[i];
        sel_data  = sel_data | req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    req_ready = (state_q == SEND) ? grant_q : '0;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(N_REQ - 1);
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
      bps_q      <= 1'b0;
      abort_q    <= 1'b0;
      lflag_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      bps_q      <= bps_d;
      abort_q    <= abort_d;
      lflag_q    <= lflag_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    bps_d      = bps_q;
    abort_d    = 1'b0;
    lflag_d    = lflag_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          for (int i = 0; i < int'(N_REQ); i++) begin
            grant_d[i] = (win_idx == IDX_W'(i));
          end
          last_d = win_idx;
          bps_d  = 1'b1;
          cnt_d  = '0;
`ifdef UART_SCHED_HDR_EN
          state_d    = HDR0;
          tx_start_d = 1'b1;
          tx_byte_d  = 8'h55;
`else
          state_d    = SEND;
`endif
        end
      end
`ifdef UART_SCHED_HDR_EN
      HDR0: begin
        if (tx_done) begin
          state_d    = HDR1;
          tx_start_d = 1'b1;
          tx_byte_d  = {4'hA, 1'b0, 3'(last_q)};
        end
      end
      HDR1: begin
        if (tx_done) begin
          state_d = SEND;
        end
      end
`endif
      SEND: begin
        if (sel_valid) begin
          tx_byte_d  = sel_data;
          tx_start_d = 1'b1;
          lflag_d    = sel_last;
          cnt_d      = '0;
          state_d    = WAIT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          // Stalled source loses the grant but keeps its rotation slot.
          abort_d = 1'b1;
          grant_d = '0;
          bps_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (lflag_q) begin
            grant_d = '0;
            bps_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        bps_d   = 1'b0;
      end
    endcase
  end

  assign grant      = grant_q;
  assign tx_start   = tx_start_q;
  assign tx_byte    = tx_byte_q;
  assign bps_clk_en = bps_q;
  assign pkt_abort  = abort_q;

endmodule
